aes_block_buffer: RTL and testbench
===================================

# aes_block_buffer

Parametrised block-assembly buffer for the AES256 datapath. It accepts a 128-bit (by default) state block as a sequence of narrow byte-beats over a valid/ready handshake and packs each block into a slot of a small multi-block FIFO. Each completed block is presented byte-parallel to the cipher core with its own valid/ready handshake. It supersedes the single fixed 16-byte write-enable register: width, beat size and depth are configurable, and it adds back-pressure, framing checks and a synchronous clear.

## Interface
- N_BYTES, 16, bytes per block; must be a multiple of BEAT_BYTES.
- BEAT_BYTES, 4, bytes per input beat; 1, 2, 4, 8 or 16.
- DEPTH, 2, block slots; power of two, at least 2.
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous flush of stored blocks, the partial block and err.
- in_valid  input  1  beat present on in_data.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_data  input  [BEAT_BYTES-1:0][7:0]  beat bytes.
- in_last  input  1  marks the final beat of a block.
- out_valid  output  1  oldest stored block is valid on out_data.
- out_ready  input  1  consumer takes the block.
- out_data  output  [N_BYTES-1:0][7:0]  oldest stored block.
- count  output  $clog2(DEPTH+1)  number of complete blocks stored.
- reg_full  output  1  count == DEPTH.
- err  output  1  sticky framing error.

## Operation
- Beat transfer occurs when in_valid && in_ready at a rising edge. Output pop occurs when out_valid && out_ready at a rising edge.
- Beat index k runs from 0 to N_BYTES/BEAT_BYTES-1. in_data[j] is written to byte k*BEAT_BYTES+j of the write slot. Bytes are stored directly into the write slot as they arrive.
- Final beat handling (k = last index):
  - The block commits: the write pointer advances, k wraps to 0, and count increments.
  - If in_last was 0 on that beat, the block still commits and err is set.
- Early in_last (in_last = 1 with k not at the last index): the beat is accepted, the partial block is discarded (k returns to 0, no commit) and err is set.
- Read side: out_data is always the read-pointer slot. out_valid = (count != 0). A pop advances the read pointer and decrements count.
- Commit and pop in the same cycle leave count unchanged. Both pointers wrap modulo DEPTH.
- in_ready = resetn && (count != DEPTH). The flag is computed from registered state only; a pop does not bypass it within the same cycle. With a block committed, the write slot is always free, so partial assembly never stalls except when count == DEPTH.
- Priority: resetn > clr > normal operation.
- Reset (resetn low at an edge):
  - all slot storage is zeroed; pointers, k and count are set to 0; err = 0;
  - outputs after reset: out_valid = 0, out_data = 0, count = 0, reg_full = 0, err = 0, in_ready = 0 while resetn is low and 1 from the first cycle resetn is high.
- clr: pointers, k, count and err go to 0. Slot data is retained, but none of it is visible because out_valid = 0. A beat or pop presented in the clr cycle is ignored.

## Timing
- Latency: out_valid rises on the edge that accepts the final beat, so it is visible the cycle after that beat is presented. out_data is stable from the same point.
- Throughput is one beat per cycle while in_ready is high.
- At count == DEPTH: in_ready is 0 during the cycle of a pop. It returns to 1 in the cycle after the pop edge.
- out_data and out_valid hold while out_valid && !out_ready.
- in_data, in_valid and in_last may change freely while in_ready is 0; they are not sampled.
- After a pop, out_data changes on the pop edge to the next slot, or out_valid falls if count becomes 0.
- err changes only on an accepted beat edge, reset, or clr.

## Test plan
- Reset: hold resetn low for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_data = 0, count = 0, err = 0. After release, in_ready = 1 and storage is unchanged until a beat is accepted.
- Single block: 4 beats carrying bytes 0x00..0x0F in order, in_last on beat 3, out_ready = 0 -> out_valid = 1 one cycle after beat 3, out_data[i] = i, count = 1.
- Back-pressure: out_ready = 0; send blocks with byte seeds 0x00, 0x0F, 0x10 (byte i = seed+i) -> after block 2, reg_full = 1 and in_ready = 0; block 3 beat 0 stalls. Then pulse out_ready -> block 0x00 pops and in_ready rises the next cycle; blocks pop in order 0x00, 0x0F, 0x10.
- Simultaneous push and pop: with count = 1 and out_ready = 1, send the final beat of the next block in the same cycle as a pop -> count stays 1 and out_data shows the new block.
- Framing: in_last on beat 1 -> err = 1, count unchanged. The next block of 4 beats commits correctly starting at byte 0. A block of 4 beats with in_last = 0 throughout also commits and keeps err = 1.
- clr mid-operation: with 1 block stored and 2 beats of the next block accepted, assert clr for one cycle -> count = 0, out_valid = 0, err = 0. The next beats assemble from byte 0 and the first following block reads back correctly.

Source files
------------

// File: rtl/aes_block_buffer.sv
// Block-assembly buffer for the AES256 datapath.
// Narrow byte-beats are packed into a slot of a small block FIFO. Each
// complete block is then presented byte-parallel to the cipher core.
// The block sets a sticky error flag on framing faults. clr flushes all
// stored blocks and the partial block without erasing slot data.
module aes_block_buffer #(
    parameter int N_BYTES    = 16,
    parameter int BEAT_BYTES = 4,
    parameter int DEPTH      = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               clr,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [BEAT_BYTES-1:0][7:0]         in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_BYTES-1:0][7:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               reg_full,
    output logic                               err
);

    localparam int N_BEATS = N_BYTES / BEAT_BYTES;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int K_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [N_BYTES-1:0][7:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q, err_d;
    logic                    accept, pop, last_beat, commit;

    // in_ready depends on registered state only, so a pop in the same cycle
    // cannot free room for a beat until the following cycle.
    assign in_ready  = resetn && (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign reg_full  = (count_q == CNT_FULL);
    assign err       = err_q;

    // A beat or a pop that arrives in a clr cycle is ignored.
    assign accept    = in_valid && in_ready && !clr;
    assign pop       = out_valid && out_ready && !clr;
    assign last_beat = (k_q == K_LAST);
    assign commit    = accept && last_beat;

    // Next-state logic for pointers, beat index, block count and error flag.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        k_d      = k_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            k_d      = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    // A full block always commits. A missing in_last is only flagged.
                    k_d      = '0;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (!in_last) err_d = 1'b1;
                end else if (in_last) begin
                    // An early in_last drops the partial block.
                    k_d   = '0;
                    err_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({commit, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment, so every register samples pre-edge values.
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            k_q      <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            k_q      <= k_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Slot storage. Each accepted beat is written straight into the write slot.
    always_ff @(posedge clk) begin
        // NOTE: the slots are reset deliberately. out_data must read zero after reset, and clr keeps the slot contents.
        if (!resetn) begin
            for (int s = 0; s < DEPTH; s++) mem_q[s] <= '0;
        end else if (accept) begin
            for (int b = 0; b < N_BEATS; b++) begin
                if (k_q == K_W'(b)) mem_q[wr_ptr_q][b*BEAT_BYTES +: BEAT_BYTES] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_buffer.sv
// Self-checking bench for aes_block_buffer with default parameters.
// The bench runs a directed vector table, hand-written multi-cycle
// sequences and a randomized phase checked against a queue-based model.
module tb_aes_block_buffer;

    localparam int DEPTH = 2;

    logic         clk = 1'b0, resetn = 1'b0, clr = 1'b0;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready, out_valid, reg_full, err;
    logic [127:0] out_data;
    logic [1:0]   count;

    int vectors = 0, miscompares = 0;

    // Reference model: a queue of complete blocks, a list of partial bytes and an error flag.
    logic [127:0] mq [$];
    logic [7:0]   mpart [$];
    logic         merr;

    always #5 clk = ~clk;

    aes_block_buffer #(.N_BYTES(16), .BEAT_BYTES(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .reg_full(reg_full), .err(err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [7:0] seed);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = seed + 8'(i);
        return r;
    endfunction

    function automatic logic [31:0] beat(input logic [7:0] seed, input int k);
        logic [127:0] b;
        b = blk(seed);
        return b[32*k +: 32];
    endfunction

    task automatic model_clear();
        mq.delete();
        mpart.delete();
        merr = 1'b0;
    endtask

    // Apply one cycle of handshake rules to the model, using pre-edge state.
    task automatic model_step(input logic c, input logic v, input logic l,
                              input logic [31:0] d, input logic r);
        logic acc, pp;
        logic [127:0] b;
        if (c) begin
            model_clear();
        end else begin
            acc = v && (mq.size() != DEPTH);
            pp  = (mq.size() != 0) && r;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                for (int j = 0; j < 4; j++) mpart.push_back(d[8*j +: 8]);
                if (mpart.size() == 16) begin
                    for (int i = 0; i < 16; i++) b[8*i +: 8] = mpart[i];
                    mq.push_back(b);
                    if (!l) merr = 1'b1;
                    mpart.delete();
                end else if (l) begin
                    mpart.delete();
                    merr = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it in, and stop 1ns after the edge.
    task automatic apply(input logic c, input logic v, input logic l,
                         input logic [31:0] d, input logic r);
        clr = c; in_valid = v; in_last = l; in_data = d; out_ready = r;
        model_step(c, v, l, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic ov,
                             input logic [1:0] cnt, input logic er);
        check({tag, " in_ready"},  128'(in_ready),  128'(rdy));
        check({tag, " out_valid"}, 128'(out_valid), 128'(ov));
        check({tag, " count"},     128'(count),     128'(cnt));
        check({tag, " reg_full"},  128'(reg_full),  128'(cnt == 2'(DEPTH)));
        check({tag, " err"},       128'(err),       128'(er));
    endtask

    task automatic send_block(input logic [7:0] seed);
        for (int k = 0; k < 4; k++) apply(1'b0, 1'b1, k == 3, beat(seed, k), 1'b0);
    endtask

    typedef struct {
        logic         c, v, l;
        logic [31:0]  d;
        logic         r;
        logic         exp_rdy, exp_ov;
        logic [1:0]   exp_cnt;
        logic         exp_err, chk_data;
        logic [127:0] exp_data;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic c, input logic v, input logic l, input logic [31:0] d,
                                input logic r, input logic er, input logic eo, input logic [1:0] ec,
                                input logic ee, input logic cd, input logic [127:0] ed);
        vec_t t;
        t = '{c, v, l, d, r, er, eo, ec, ee, cd, ed};
        tbl.push_back(t);
    endfunction

    initial begin
        logic c, v, l, r;
        logic [31:0] d;

        // Reset held for two cycles while a beat is offered.
        in_valid = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  128'(in_ready),  128'(0));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_data",  out_data,        128'(0));
        check("rst count",     128'(count),     128'(0));
        check("rst err",       128'(err),       128'(0));
        resetn = 1'b1; in_valid = 1'b0;
        #1;
        check("rel in_ready",  128'(in_ready),  128'(1));
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rel out_data",  out_data,        128'(0));
        check("rel count",     128'(count),     128'(0));

        // Directed table: one block, a pop, an early in_last, a recovery block and a block without in_last.
        for (int k = 0; k < 4; k++)
            add(0, 1, k == 3, beat(8'h00, k), 0, 1, k == 3, 2'(k == 3), 0, k == 3, blk(8'h00));
        add(0, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0, '0);
        add(0, 1, 0, 32'hAAAA_AAAA, 0, 1, 0, 0, 0, 0, '0);
        add(0, 1, 1, 32'hBBBB_BBBB, 0, 1, 0, 0, 1, 0, '0);
        for (int k = 0; k < 4; k++)
            add(0, 1, k == 3, beat(8'h20, k), 0, 1, k == 3, 2'(k == 3), 1, k == 3, blk(8'h20));
        add(0, 0, 0, 32'h0, 1, 1, 0, 0, 1, 0, '0);
        for (int k = 0; k < 4; k++)
            add(0, 1, 0, beat(8'h30, k), 0, 1, k == 3, 2'(k == 3), 1, k == 3, blk(8'h30));
        add(0, 0, 0, 32'h0, 1, 1, 0, 0, 1, 0, '0);

        foreach (tbl[i]) begin
            apply(tbl[i].c, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].r);
            chk_state($sformatf("tbl%0d", i), tbl[i].exp_rdy, tbl[i].exp_ov, tbl[i].exp_cnt, tbl[i].exp_err);
            if (tbl[i].chk_data) check($sformatf("tbl%0d out_data", i), out_data, tbl[i].exp_data);
        end

        // Back-pressure: fill both slots, then stall the next beat until a pop.
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_state("clr0", 1, 0, 0, 0);
        send_block(8'h00);
        send_block(8'h0F);
        chk_state("full", 0, 1, 2, 0);
        apply(1'b0, 1'b1, 1'b0, beat(8'h10, 0), 1'b0);
        apply(1'b0, 1'b1, 1'b0, beat(8'h10, 0), 1'b0);
        chk_state("stall", 0, 1, 2, 0);
        check("stall out_data", out_data, blk(8'h00));
        apply(1'b0, 1'b1, 1'b0, beat(8'h10, 0), 1'b1);
        chk_state("pop0", 1, 1, 1, 0);
        check("pop0 out_data", out_data, blk(8'h0F));
        send_block(8'h10);
        chk_state("refill", 0, 1, 2, 0);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("pop1 out_data", out_data, blk(8'h10));
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_state("drain", 1, 0, 0, 0);

        // Commit and pop in the same cycle.
        send_block(8'h40);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 1'b0, beat(8'h50, k), 1'b0);
        apply(1'b0, 1'b1, 1'b1, beat(8'h50, 3), 1'b1);
        chk_state("pushpop", 1, 1, 1, 0);
        check("pushpop out_data", out_data, blk(8'h50));
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // clr mid-block, with err set beforehand.
        apply(1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        chk_state("err set", 1, 0, 0, 1);
        send_block(8'h60);
        apply(1'b0, 1'b1, 1'b0, beat(8'h70, 0), 1'b0);
        apply(1'b0, 1'b1, 1'b0, beat(8'h70, 1), 1'b0);
        apply(1'b1, 1'b1, 1'b0, beat(8'h80, 0), 1'b1);
        chk_state("clr", 1, 0, 0, 0);
        send_block(8'h90);
        chk_state("postclr", 1, 1, 1, 0);
        check("postclr out_data", out_data, blk(8'h90));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom_range(63) == 0);
            v = ($urandom_range(3) != 0);
            l = (mpart.size() == 12) ^ ($urandom_range(15) == 0);
            d = $urandom;
            r = $urandom_range(1);
            apply(c, v, l, d, r);
            check("rnd in_ready",  128'(in_ready),  128'(mq.size() != DEPTH));
            check("rnd out_valid", 128'(out_valid), 128'(mq.size() != 0));
            check("rnd count",     128'(count),     128'(mq.size()));
            check("rnd reg_full",  128'(reg_full),  128'(mq.size() == DEPTH));
            check("rnd err",       128'(err),       128'(merr));
            if (mq.size() != 0) check("rnd out_data", out_data, mq[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
